// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer: register word indices, CTRL bit positions
// and the APB transfer state encoding.
package apb_timer_pkg;

   // Register word index = byte offset / 4, taken from paddr[4:2].
   localparam logic [2:0] CTRL_OFS     = 3'd0;
   localparam logic [2:0] PRESCALE_OFS = 3'd1;
   localparam logic [2:0] COUNT_OFS    = 3'd2;
   localparam logic [2:0] COMPARE_OFS  = 3'd3;
   localparam logic [2:0] STATUS_OFS   = 3'd4;

   localparam int CTRL_EN          = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_IRQ_EN      = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_timer_unit_if.sv
// APB bus bundle between one node master port and the timer slave.
interface apb_timer_unit_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic                  psel;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (output penable, pwrite, paddr, psel, pwdata,
                   input  prdata, pready, pslverr);
   modport slave  (input  penable, pwrite, paddr, psel, pwdata,
                   output prdata, pready, pslverr);
endinterface

// File: rtl/apb_timer_prescaler.sv
// Prescaler for the APB timer: pcnt runs 0..P while enabled and tick pulses on pcnt==P.
module apb_timer_prescaler (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic [15:0] presc_i,
   input  logic        restart_i,
   output logic        tick_o
);

   logic [15:0] pcnt_q, pcnt_d;

   assign tick_o = en_i & (pcnt_q == presc_i);

   always_comb begin
      pcnt_d = pcnt_q + 16'd1;
      if (!en_i || restart_i || tick_o) begin
         pcnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/apb_timer_unit.sv
// APB timer peripheral: prescaled up-counter, compare, sticky MATCH and level irq.
// Define APB_TIMER_WAIT_STATE_EN to insert exactly one wait state per transfer.
module apb_timer_unit
   import apb_timer_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int APB_DATA_WIDTH = 32,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      penable_i,
   input  logic                      pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
   input  logic                      psel_i,
   input  logic [APB_DATA_WIDTH-1:0] pwdata_i,
   output logic [APB_DATA_WIDTH-1:0] prdata_o,
   output logic                      pready_o,
   output logic                      pslverr_o,
   output logic                      irq_o
);

   apb_state_e                state_q, state_d;
   logic [2:0]                addr_q, addr_d;
   logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic [2:0]                ctrl_q, ctrl_d;
   logic [15:0]               presc_q, presc_d;
   logic [CNT_WIDTH-1:0]      count_q, count_d;
   logic [CNT_WIDTH-1:0]      cmp_q, cmp_d;
   logic                      match_q, match_d;
   logic                      irq_q, irq_d;

   logic                      setup, done, wr_en, addr_err, tick, restart, hit;
   logic [2:0]                rd_idx;
   logic [APB_DATA_WIDTH-1:0] rd_data;
   logic                      unused_bits;

   assign unused_bits = ^{paddr_i[APB_ADDR_WIDTH-1:5], paddr_i[1:0], pwdata_i};

   // Handshake: a transfer starts with psel=1/penable=0 (setup) and completes on the
   // single cycle where pready_o=1; pwrite/paddr/pwdata are held stable until then,
   // and pslverr_o/prdata_o are only meaningful while pready_o=1.
   assign setup    = psel_i & ~penable_i;
   assign addr_err = (addr_q > STATUS_OFS);
`ifdef APB_TIMER_WAIT_STATE_EN
   assign done     = (state_q == WAIT);
`else
   assign done     = (state_q == ACCESS) & psel_i & penable_i;
`endif
   assign wr_en    = done & pwrite_i & ~addr_err;
   assign hit      = (count_q == cmp_q);
   assign restart  = wr_en & ((addr_q == PRESCALE_OFS) |
                              ((addr_q == CTRL_OFS) & ~pwdata_i[CTRL_EN]));

   apb_timer_prescaler u_prescaler (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (ctrl_q[CTRL_EN]),
      .presc_i   (presc_q),
      .restart_i (restart),
      .tick_o    (tick)
   );

   // Setup decodes the live address; later samples use the latched one.
   assign rd_idx = (state_q == IDLE) ? paddr_i[4:2] : addr_q;

   always_comb begin
      rd_data = '0;
      unique case (rd_idx)
         CTRL_OFS:     rd_data[2:0]           = ctrl_q;
         PRESCALE_OFS: rd_data[15:0]          = presc_q;
         COUNT_OFS:    rd_data[CNT_WIDTH-1:0] = count_q;
         COMPARE_OFS:  rd_data[CNT_WIDTH-1:0] = cmp_q;
         STATUS_OFS:   rd_data[0]             = match_q;
         default:      rd_data                = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      prdata_d = prdata_q;
      unique case (state_q)
         IDLE: begin
            prdata_d = '0;
            if (setup) begin
               state_d  = ACCESS;
               addr_d   = paddr_i[4:2];
               prdata_d = rd_data;
            end
         end
`ifdef APB_TIMER_WAIT_STATE_EN
         ACCESS: begin
            state_d  = WAIT;
            prdata_d = rd_data;
         end
         WAIT: begin
            state_d  = IDLE;
            prdata_d = '0;
         end
`else
         ACCESS: begin
            if (done) begin
               state_d  = IDLE;
               prdata_d = '0;
            end
         end
`endif
         default: begin
            state_d  = IDLE;
            prdata_d = '0;
         end
      endcase
   end

   // Priority: tick update, then bus write (COUNT write wins), then MATCH set (beats clear).
   always_comb begin
      ctrl_d  = ctrl_q;
      presc_d = presc_q;
      count_d = count_q;
      cmp_d   = cmp_q;
      match_d = match_q;
      irq_d   = match_q & ctrl_q[CTRL_IRQ_EN];
      if (tick) begin
         count_d = (hit && ctrl_q[CTRL_AUTO_RELOAD]) ? '0 : count_q + CNT_WIDTH'(1);
      end
      if (wr_en) begin
         unique case (addr_q)
            CTRL_OFS:     ctrl_d  = pwdata_i[2:0];
            PRESCALE_OFS: presc_d = pwdata_i[15:0];
            COUNT_OFS:    count_d = pwdata_i[CNT_WIDTH-1:0];
            COMPARE_OFS:  cmp_d   = pwdata_i[CNT_WIDTH-1:0];
            STATUS_OFS:   if (pwdata_i[0]) match_d = 1'b0;
            default:      ;
         endcase
      end
      if (tick && hit) begin
         match_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         prdata_q <= '0;
         ctrl_q   <= '0;
         presc_q  <= '0;
         count_q  <= '0;
         cmp_q    <= '0;
         match_q  <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         prdata_q <= prdata_d;
         ctrl_q   <= ctrl_d;
         presc_q  <= presc_d;
         count_q  <= count_d;
         cmp_q    <= cmp_d;
         match_q  <= match_d;
         irq_q    <= irq_d;
      end
   end

   assign prdata_o  = prdata_q;
   assign pready_o  = done;
   assign pslverr_o = done & addr_err;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_apb_timer_unit.sv
// Randomised scoreboard bench for apb_timer_unit; builds with or without
// APB_TIMER_WAIT_STATE_EN and adapts its transfer timing to match.
module tb_apb_timer_unit;
   import apb_timer_pkg::*;

   localparam int AW = 12;
   localparam int DW = 32;
`ifdef APB_TIMER_WAIT_STATE_EN
   localparam int COLL_K = 2;
`else
   localparam int COLL_K = 1;
`endif

   logic clk;
   logic rst_ni;
   logic irq;

   apb_timer_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_timer_unit #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .CNT_WIDTH(32)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .penable_i (bus.penable),
      .pwrite_i  (bus.pwrite),
      .paddr_i   (bus.paddr),
      .psel_i    (bus.psel),
      .pwdata_i  (bus.pwdata),
      .prdata_o  (bus.prdata),
      .pready_o  (bus.pready),
      .pslverr_o (bus.pslverr),
      .irq_o     (irq)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [2:0]  m_ctrl;
   logic [15:0] m_presc;
   logic [31:0] m_count, m_cmp;
   logic        m_match, m_irq;
   int          m_run;   // cycles since the prescaler phase last restarted

   // expected response: {is_read, pslverr, prdata}
   logic [33:0] exp_q[$];
   logic        exp_rdy, exp_pr0;
   int          n_chk, n_fail;

   function automatic logic [31:0] read_model(input int idx);
      case (idx)
         0:       return {29'd0, m_ctrl};
         1:       return {16'd0, m_presc};
         2:       return m_count;
         3:       return m_cmp;
         4:       return {31'd0, m_match};
         default: return 32'd0;
      endcase
   endfunction

   // One clock: derive the register state after the edge from the rules, given
   // what the bench drives this cycle, then advance to just after that edge.
   task automatic cyc(input bit wr, input int idx, input logic [31:0] d);
      bit          tk, eq;
      logic [2:0]  nctl;
      logic [15:0] npr;
      logic [31:0] ncnt, ncmp;
      logic        nmat, nirq;
      int          nrun;
      tk   = m_ctrl[0] && ((m_run % (int'(m_presc) + 1)) == int'(m_presc));
      eq   = (m_count == m_cmp);
      nctl = m_ctrl; npr = m_presc; ncmp = m_cmp;
      ncnt = m_count;
      nmat = m_match;
      nirq = m_match && m_ctrl[2];
      if (tk) ncnt = (eq && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
      if (wr) begin
         if (idx == 0) nctl = d[2:0];
         if (idx == 1) npr  = d[15:0];
         if (idx == 2) ncnt = d;
         if (idx == 3) ncmp = d;
         if (idx == 4 && d[0]) nmat = 1'b0;
      end
      if (tk && eq) nmat = 1'b1;
      nrun = (!m_ctrl[0] || (wr && (idx == 1 || (idx == 0 && !d[0])))) ? 0 : m_run + 1;
      if (rst_ni !== 1'b1) begin
         nctl = '0; npr = '0; ncnt = '0; ncmp = '0; nmat = 1'b0; nirq = 1'b0; nrun = 0;
      end
      @(posedge clk);
      m_ctrl = nctl; m_presc = npr; m_count = ncnt; m_cmp = ncmp;
      m_match = nmat; m_irq = nirq; m_run = nrun;
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      bus.psel = 1'b0; bus.penable = 1'b0;
      exp_rdy = 1'b0; exp_pr0 = 1'b1;
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 32'd0);
   endtask

   task automatic apb_xfer(input bit wr, input int idx, input logic [31:0] d);
      logic [31:0] rv;
      bit          err;
      err = (idx > 4);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
      bus.paddr = AW'(idx * 4); bus.pwdata = d;
      exp_rdy = 1'b0; exp_pr0 = 1'b1;
`ifdef APB_TIMER_WAIT_STATE_EN
      cyc(1'b0, 0, 32'd0);
      bus.penable = 1'b1; exp_pr0 = 1'b0;
      rv = read_model(idx);
      cyc(1'b0, 0, 32'd0);
      exp_rdy = 1'b1;
`else
      rv = read_model(idx);
      cyc(1'b0, 0, 32'd0);
      bus.penable = 1'b1; exp_pr0 = 1'b0; exp_rdy = 1'b1;
`endif
      exp_q.push_back({~wr, err, (wr || err) ? 32'd0 : rv});
      cyc(wr && !err, idx, d);
      bus.psel = 1'b0; bus.penable = 1'b0; exp_rdy = 1'b0; exp_pr0 = 1'b1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = '0; bus.pwdata = '0;
      exp_rdy = 1'b0; exp_pr0 = 1'b1;
      cyc(1'b0, 0, 32'd0);
      cyc(1'b0, 0, 32'd0);
      rst_ni = 1'b1;
   endtask

   task automatic reset_in_access(input logic [31:0] d);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
      bus.paddr = AW'(12); bus.pwdata = d;
      exp_rdy = 1'b0; exp_pr0 = 1'b1;
      cyc(1'b0, 0, 32'd0);
      bus.penable = 1'b1; rst_ni = 1'b0;
      cyc(1'b1, 3, d);
      bus.psel = 1'b0; bus.penable = 1'b0;
      cyc(1'b0, 0, 32'd0);
      rst_ni = 1'b1;
   endtask

   // ---------------- scoreboard / monitor ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [33:0] e;
      if (rst_ni === 1'b1) begin
         chk("pready", {31'd0, bus.pready}, {31'd0, exp_rdy});
         chk("irq", {31'd0, irq}, {31'd0, m_irq});
         if (bus.pready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_completion: pready high with no transfer pending");
            end else begin
               e = exp_q.pop_front();
               chk("pslverr", {31'd0, bus.pslverr}, {31'd0, e[32]});
               if (e[33]) chk("prdata", bus.prdata, e[31:0]);
            end
         end else if (exp_pr0) begin
            chk("prdata_idle", bus.prdata, 32'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] x, d;
      int          idx, p, c;
      bit          wr;
      n_chk = 0; n_fail = 0;
      m_ctrl = '0; m_presc = '0; m_count = '0; m_cmp = '0;
      m_match = 1'b0; m_irq = 1'b0; m_run = 0;

      // reset values of all registers
      do_reset();
      for (int i = 0; i < 5; i++) apb_xfer(1'b0, i, 32'd0);

      // match with auto-reload and interrupt
      p = $urandom_range(1, 3);
      c = $urandom_range(2, 6);
      apb_xfer(1'b1, PRESCALE_OFS, p);
      apb_xfer(1'b1, COMPARE_OFS, c);
      apb_xfer(1'b1, CTRL_OFS, 32'h7);
      idle((c + 1) * (p + 1) + 2);
      apb_xfer(1'b0, STATUS_OFS, 32'd0);
      apb_xfer(1'b0, COUNT_OFS, 32'd0);

      // counter wrap from all-ones, no match
      apb_xfer(1'b1, CTRL_OFS, 32'h0);
      apb_xfer(1'b1, COUNT_OFS, 32'hFFFF_FFFF);
      apb_xfer(1'b1, PRESCALE_OFS, 32'h0);
      apb_xfer(1'b1, COMPARE_OFS, 32'h10);
      apb_xfer(1'b1, STATUS_OFS, 32'h1);
      apb_xfer(1'b1, CTRL_OFS, 32'h1);
      apb_xfer(1'b0, COUNT_OFS, 32'd0);
      apb_xfer(1'b0, STATUS_OFS, 32'd0);

      // COUNT write against running ticks, then STATUS clear colliding with a match
      apb_xfer(1'b1, COUNT_OFS, 32'h100);
      apb_xfer(1'b0, COUNT_OFS, 32'd0);
      x = $urandom_range(32'h200, 32'h1000);
      apb_xfer(1'b1, CTRL_OFS, 32'h0);
      apb_xfer(1'b1, COMPARE_OFS, x + COLL_K);
      apb_xfer(1'b1, STATUS_OFS, 32'h1);
      apb_xfer(1'b1, CTRL_OFS, 32'h5);
      apb_xfer(1'b1, COUNT_OFS, x);
      apb_xfer(1'b1, STATUS_OFS, 32'h1);
      apb_xfer(1'b0, STATUS_OFS, 32'd0);
      idle(3);

      // unmapped offsets
      apb_xfer(1'b0, 6, 32'd0);
      apb_xfer(1'b1, 7, 32'hFFFF_FFFF);
      for (int i = 0; i < 5; i++) apb_xfer(1'b0, i, 32'd0);

      // randomised mix of transfers and idle gaps
      for (int i = 0; i < 40; i++) begin
         idx = $urandom_range(0, 7);
         wr  = 1'($urandom_range(0, 1));
         case (idx)
            0:       d = $urandom_range(0, 7);
            1:       d = $urandom_range(0, 3);
            3:       d = $urandom_range(0, 24);
            4:       d = $urandom_range(0, 1);
            default: d = $urandom;
         endcase
         apb_xfer(wr, idx, d);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end

      // reset during the access phase of a COMPARE write
      apb_xfer(1'b1, COMPARE_OFS, 32'h55);
      reset_in_access($urandom | 32'h1);
      apb_xfer(1'b0, COMPARE_OFS, 32'd0);
      apb_xfer(1'b0, CTRL_OFS, 32'd0);
      idle(3);

      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_responses: got %0d left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_timer_unit.md
# apb_timer_unit

APB slave timer peripheral on one master port of the APB node. It holds a prescaled up-counter with a compare register, a sticky match flag and a level interrupt, all programmed over APB. The node's per-master `penable/pwrite/paddr/psel/pwdata` outputs drive this block directly. Its `prdata/pready/pslverr` outputs return to the node.

## Interface
- `APB_ADDR_WIDTH`, default 12: paddr width; only `paddr_i[4:2]` is decoded.
- `APB_DATA_WIDTH`, default 32: pwdata/prdata width; must be 32.
- `CNT_WIDTH`, default 32: counter/compare width, 1..32; upper register bits read 0.

Ports:
- `clk_i`  in  1  single clock
- `rst_ni`  in  1  reset, synchronous, active-low
- `penable_i`  in  1  APB enable
- `pwrite_i`  in  1  APB write
- `paddr_i`  in  APB_ADDR_WIDTH  APB address
- `psel_i`  in  1  APB select
- `pwdata_i`  in  APB_DATA_WIDTH  write data
- `prdata_o`  out  APB_DATA_WIDTH  read data
- `pready_o`  out  1  transfer complete
- `pslverr_o`  out  1  error response
- `irq_o`  out  1  interrupt, registered level

## Operation
- Registers, at byte offset `paddr_i[4:2]`×4:
  - 0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN.
  - 0x04 PRESCALE: [15:0] P.
  - 0x08 COUNT: read/write.
  - 0x0C COMPARE: read/write.
  - 0x10 STATUS: [0] MATCH; a write of 1 clears it, a write of 0 has no effect.
- Offsets 0x14–0x1C:
  - reads return 0; writes have no effect.
  - `pslverr_o`=1 on the completing cycle.
- Prescaler, counter `pcnt` 16 bit:
  - When EN=1, it counts 0..P, and `tick` pulses on the cycle `pcnt`==P.
  - When EN=0, `pcnt` is held at 0 and there is no tick.
- On tick:
  - If COUNT==COMPARE, MATCH←1. COUNT←0 if AUTO_RELOAD, else COUNT+1.
  - Otherwise COUNT←COUNT+1, modulo 2^CNT_WIDTH (wraps to 0).
- `irq_o` ← MATCH & IRQ_EN, registered (one cycle after MATCH sets).
- APB FSM states: IDLE, ACCESS, WAIT (WAIT exists only with the macro).
  - IDLE→ACCESS on `psel_i & ~penable_i`.
  - ACCESS→IDLE when `pready_o`=1.
- Simultaneous events:
  - An APB write to COUNT wins over a same-cycle tick increment.
  - A STATUS clear loses to a same-cycle MATCH set (MATCH stays 1).
  - A write to PRESCALE or a write of EN=0 resets `pcnt` to 0.
- Reset mid-transfer: FSM returns to IDLE and outputs take their reset values. A partially performed write has no effect.
- Reset values:
  - registers 0, `pcnt` 0, FSM IDLE.
  - outputs `prdata_o`=0, `pready_o`=0, `pslverr_o`=0, `irq_o`=0.

## Timing
- Setup cycle (`psel_i`=1, `penable_i`=0): address decoded; read data registered into `prdata_o` at the end of this cycle.
- Without the macro:
  - `pready_o` is combinational `psel_i & penable_i` while in ACCESS, giving zero wait states.
  - The write commits on the clock edge ending the access cycle.
  - Read data is valid during the access cycle.
- `prdata_o` returns to 0 on the cycle after completion; `pslverr_o` is valid only while `pready_o`=1.
- Reads of COUNT return the value sampled at the setup-cycle edge.
- Latency from tick to MATCH: 1 cycle. From MATCH to `irq_o`: 1 cycle.

## Configuration
- `APB_TIMER_WAIT_STATE_EN`:
  - Defined: ACCESS→WAIT unconditionally. `pready_o`=1 only in WAIT, giving exactly one wait state. The write commits at the end of WAIT. `prdata_o` is re-sampled at the end of ACCESS, so a read returns COUNT one cycle later than without the macro.
  - Undefined: WAIT is not compiled and behaviour is as in Timing.

## Structure
- Package `apb_timer_pkg` holds:
  - register offset localparams (`CTRL_OFS`…`STATUS_OFS`);
  - CTRL bit index constants;
  - the `apb_state_e` enum (IDLE/ACCESS/WAIT).
- Sub-module `apb_timer_prescaler` (inputs: clk, rst, en, P, restart; output: tick) holds `pcnt`.
- The register file, counter and APB FSM live in the top module.

## Test plan
- Reset with `rst_ni` low for 2 cycles, then read all 5 registers → all 0, `pslverr_o`=0, `irq_o`=0.
- Write PRESCALE=3, COMPARE=5, CTRL=0x7; wait 24 cycles → MATCH=1, COUNT=0 (auto-reload), `irq_o`=1 one cycle after MATCH.
- With COUNT=0xFFFF_FFFF, P=0, CTRL=0x1, compare 0x10 → after 1 tick COUNT=0 (wrap), MATCH=0.
- While ticks run each cycle, write COUNT=0x100 → next read is 0x100 or 0x101, never the pre-write count+1. Writing STATUS=1 on the same cycle as a match leaves MATCH=1.
- Read 0x18 → `prdata_o`=0 and `pslverr_o`=1. Write 0x1C=0xFFFF_FFFF → no register changes.
- Run with and without `APB_TIMER_WAIT_STATE_EN`: a back-to-back write then read completes in 4 vs 6 cycles, and `pready_o` pulse width is 1 in both. Assert `rst_ni` low during ACCESS of a write to COMPARE → COMPARE reads 0 after reset.
